counter_sequencer: RTL and testbench

Control FSM that sequences a WIDTH-bit up counter. It supports start/stop/hold commands, a programmable terminal value, and one-shot or auto-reload modes. It emits a one-cycle tick at each terminal event and level busy/done status. It sits between software-style command strobes and the counter datapath, so upstream logic never drives counter enables directly.

---
 rtl/counter_seq_pkg.sv | 17 +
 rtl/counter_sequencer_if.sv | 50 +++++
 rtl/up_counter_core.sv | 29 ++
 rtl/counter_sequencer.sv | 160 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/counter_seq_pkg.sv
// counter_seq_pkg: shared types and defaults for the counter sequencer slice.
//   state_t        : sequencer FSM state encoding (IDLE/RUN/HOLD/DONE)
//   DEF_WIDTH      : default counter / terminal-value width
//   DEF_PRESCALE_W : default prescaler width (COUNTER_SEQ_PRESCALE_EN builds)
package counter_seq_pkg;

   localparam int DEF_WIDTH      = 4;
   localparam int DEF_PRESCALE_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      RUN  = 2'b01,
      HOLD = 2'b10,
      DONE = 2'b11
   } state_t;

endpackage

// File: rtl/counter_sequencer_if.sv
// counter_sequencer_if: command/status bundle between a controller and the
// counter sequencer.
//   start, stop   : command pulses
//   hold          : level, freezes the count while in RUN
//   auto_reload   : mode, sampled at start (1 = periodic, 0 = one-shot)
//   term_val      : terminal count, sampled at start
//   prescale      : prescaler reload, sampled at start (COUNTER_SEQ_PRESCALE_EN only)
//   count         : current counter value
//   tick          : one-cycle pulse per terminal event
//   busy, done    : level status
// Modports: master (controller side), slave (sequencer side).
interface counter_sequencer_if
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef COUNTER_SEQ_PRESCALE_EN
   , parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
);

   logic             start;
   logic             stop;
   logic             hold;
   logic             auto_reload;
   logic [WIDTH-1:0] term_val;
`ifdef COUNTER_SEQ_PRESCALE_EN
   logic [PRESCALE_W-1:0] prescale;
`endif
   logic [WIDTH-1:0] count;
   logic             tick;
   logic             busy;
   logic             done;

   modport master (
      output start, stop, hold, auto_reload, term_val,
`ifdef COUNTER_SEQ_PRESCALE_EN
      output prescale,
`endif
      input  count, tick, busy, done
   );

   modport slave (
      input  start, stop, hold, auto_reload, term_val,
`ifdef COUNTER_SEQ_PRESCALE_EN
      input  prescale,
`endif
      output count, tick, busy, done
   );

endinterface

// File: rtl/up_counter_core.sv
// up_counter_core: WIDTH-bit up counter register.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   clr : synchronous clear (wins over en)
//   en  : increment enable
//   q   : counter value
module up_counter_core
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         q <= '0;
      end else if (clr) begin
         q <= '0;
      end else if (en) begin
         q <= q + 1'b1;
      end
   end

endmodule

// File: rtl/counter_sequencer.sv
// counter_sequencer: control FSM sequencing a WIDTH-bit up counter with
// start/stop/hold commands, programmable terminal value and one-shot or
// auto-reload modes.
//   clk : rising-edge clock
//   rst : asynchronous active-low reset
//   bus : counter_sequencer_if.slave (commands in, count/tick/busy/done out)
// Optional macro COUNTER_SEQ_PRESCALE_EN adds a prescaler (bus.prescale) so
// the counter steps once every prescale+1 RUN cycles.
module counter_sequencer
   import counter_seq_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
`ifdef COUNTER_SEQ_PRESCALE_EN
   , parameter int PRESCALE_W = DEF_PRESCALE_W
`endif
) (
   input  logic                   clk,
   input  logic                   rst,
   counter_sequencer_if.slave     bus
);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] count;
   logic [WIDTH-1:0] term_sh;
   logic             reload_sh;
   logic             clr;
   logic             en;
   logic             load;
   logic             tick_nx;
   logic             busy_nx;
   logic             done_nx;
   logic             tick_q;
   logic             busy_q;
   logic             done_q;
   logic             at_term;
   logic             step;

   assign at_term = (count == term_sh);

`ifdef COUNTER_SEQ_PRESCALE_EN
   logic [PRESCALE_W-1:0] psc_cnt;
   logic [PRESCALE_W-1:0] psc_sh;

   // step marks the RUN cycle on which the counter may act
   assign step = (psc_cnt == psc_sh);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psc_cnt <= '0;
         psc_sh  <= '0;
      end else if (bus.stop) begin
         psc_cnt <= '0;
      end else if (load) begin
         psc_cnt <= '0;
         psc_sh  <= bus.prescale;
      end else if (state == RUN && !bus.hold) begin
         psc_cnt <= step ? '0 : psc_cnt + 1'b1;
      end
   end
`else
   assign step = 1'b1;
`endif

   // state register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // next-state logic; stop outranks start, start outranks hold
   always_comb begin
      state_nx = state;
      if (bus.stop) begin
         state_nx = IDLE;
      end else begin
         case (state)
            IDLE, DONE: if (bus.start) state_nx = RUN;
            RUN: begin
               if (bus.hold) begin
                  state_nx = HOLD;
               end else if (step && at_term && !reload_sh) begin
                  state_nx = DONE;
               end
            end
            HOLD: if (!bus.hold) state_nx = RUN;
            default: state_nx = IDLE;
         endcase
      end
   end

   // datapath controls and next values of the registered status outputs
   always_comb begin
      clr     = 1'b0;
      en      = 1'b0;
      load    = 1'b0;
      tick_nx = 1'b0;
      if (bus.stop) begin
         clr = 1'b1;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (bus.start) begin
                  load = 1'b1;
                  clr  = 1'b1;
               end
            end
            RUN: begin
               // hold defers the terminal check as well as the increment
               if (!bus.hold && step) begin
                  if (at_term) begin
                     tick_nx = 1'b1;
                     clr     = reload_sh;
                  end else begin
                     en = 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
      busy_nx = (state_nx == RUN) || (state_nx == HOLD);
      done_nx = (state_nx == DONE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tick_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         term_sh   <= '0;
         reload_sh <= 1'b0;
      end else begin
         tick_q <= tick_nx;
         busy_q <= busy_nx;
         done_q <= done_nx;
         if (load) begin
            term_sh   <= bus.term_val;
            reload_sh <= bus.auto_reload;
         end
      end
   end

   up_counter_core #(.WIDTH(WIDTH)) u_core (
      .clk (clk),
      .rst (rst),
      .clr (clr),
      .en  (en),
      .q   (count)
   );

   assign bus.count = count;
   assign bus.tick  = tick_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: directed self-checking bench for counter_sequencer.
// Inputs change 1 ns after a rising edge; outputs are checked at that point.
module tb_counter_sequencer;

   localparam int W = 4;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   counter_sequencer_if #(.WIDTH(W)) bus ();

   counter_sequencer #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag, input logic [W-1:0] c, input logic t,
                          input logic b, input logic d);
      chk({tag, ".count"}, 32'(bus.count), 32'(c));
      chk({tag, ".tick"},  32'(bus.tick),  32'(t));
      chk({tag, ".busy"},  32'(bus.busy),  32'(b));
      chk({tag, ".done"},  32'(bus.done),  32'(d));
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic go(input logic [W-1:0] tv, input logic ar);
      bus.term_val    = tv;
      bus.auto_reload = ar;
      bus.start       = 1'b1;
      cyc(1);
      bus.start       = 1'b0;
   endtask

   task automatic do_stop();
      bus.stop = 1'b1;
      cyc(1);
      bus.stop = 1'b0;
   endtask

   initial begin
      logic [W-1:0] rl_cnt [6];
      logic         rl_tick[6];
      rl_cnt  = '{4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0};
      rl_tick = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      n_cmp = 0;
      n_err = 0;
      rst   = 1'b0;
      bus.start = 1'b0; bus.stop = 1'b0; bus.hold = 1'b0;
      bus.auto_reload = 1'b0; bus.term_val = '0;
`ifdef COUNTER_SEQ_PRESCALE_EN
      bus.prescale = '0;
`endif
      cyc(2);
      chk_all("reset", 4'd0, 1'b0, 1'b0, 1'b0);
      rst = 1'b1;
      cyc(1);

      // one-shot to 3
      go(4'd3, 1'b0);
      chk_all("os.start", 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 1; i <= 3; i++) begin
         cyc(1);
         chk_all("os.run", 4'(i), 1'b0, 1'b1, 1'b0);
      end
      cyc(1);
      chk_all("os.term", 4'd3, 1'b1, 1'b0, 1'b1);
      cyc(1);
      chk_all("os.done", 4'd3, 1'b0, 1'b0, 1'b1);
      go(4'd3, 1'b0);
      chk_all("os.restart", 4'd0, 1'b0, 1'b1, 1'b0);
      do_stop();
      chk_all("os.stop", 4'd0, 1'b0, 1'b0, 1'b0);

      // async reset mid-count
      go(4'd7, 1'b0);
      cyc(5);
      chk("rst.pre", 32'(bus.count), 32'd5);
      rst = 1'b0;
      #1;
      chk_all("rst.async", 4'd0, 1'b0, 1'b0, 1'b0);
      cyc(1);
      rst = 1'b1;

      // auto-reload period 3
      go(4'd2, 1'b1);
      chk_all("rl.start", 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cyc(1);
         chk_all("rl.seq", rl_cnt[i], rl_tick[i], 1'b1, 1'b0);
      end
      do_stop();
      chk_all("rl.stop", 4'd0, 1'b0, 1'b0, 1'b0);

      // hold at terminal defers the tick
      go(4'd4, 1'b1);
      cyc(4);
      chk("hold.pre", 32'(bus.count), 32'd4);
      bus.hold = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk_all("hold.frz", 4'd4, 1'b0, 1'b1, 1'b0);
      end
      bus.hold = 1'b0;
      cyc(1);
      chk_all("hold.rel", 4'd4, 1'b0, 1'b1, 1'b0);
      cyc(1);
      chk_all("hold.tick", 4'd0, 1'b1, 1'b1, 1'b0);
      do_stop();

      // stop at terminal suppresses the tick
      go(4'd1, 1'b1);
      cyc(1);
      chk("stopterm.pre", 32'(bus.count), 32'd1);
      do_stop();
      chk_all("stopterm", 4'd0, 1'b0, 1'b0, 1'b0);

      // start+stop together in RUN: stop wins
      go(4'd5, 1'b0);
      cyc(2);
      bus.start = 1'b1;
      bus.stop  = 1'b1;
      cyc(1);
      bus.start = 1'b0;
      bus.stop  = 1'b0;
      chk_all("startstop", 4'd0, 1'b0, 1'b0, 1'b0);

      // start in RUN with new term_val is ignored
      go(4'd5, 1'b0);
      cyc(1);
      bus.term_val = 4'd1;
      bus.start    = 1'b1;
      cyc(1);
      bus.start    = 1'b0;
      chk_all("ign.start", 4'd2, 1'b0, 1'b1, 1'b0);
      cyc(3);
      chk_all("ign.five", 4'd5, 1'b0, 1'b1, 1'b0);
      cyc(1);
      chk_all("ign.done", 4'd5, 1'b1, 1'b0, 1'b1);

      // term 0 one-shot
      go(4'd0, 1'b0);
      chk_all("z.os.start", 4'd0, 1'b0, 1'b1, 1'b0);
      cyc(1);
      chk_all("z.os.done", 4'd0, 1'b1, 1'b0, 1'b1);

      // term 0 reload: tick every cycle
      go(4'd0, 1'b1);
      chk_all("z.rl.start", 4'd0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc(1);
         chk_all("z.rl", 4'd0, 1'b1, 1'b1, 1'b0);
      end
      do_stop();

      // max terminal: wrap coincides with reload
      go(4'd15, 1'b1);
      cyc(15);
      chk_all("max.top", 4'd15, 1'b0, 1'b1, 1'b0);
      cyc(1);
      chk_all("max.wrap", 4'd0, 1'b1, 1'b1, 1'b0);
      do_stop();

`ifdef COUNTER_SEQ_PRESCALE_EN
      begin
         logic [W-1:0] ps_cnt [12];
         ps_cnt = '{4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0,
                    4'd0, 4'd0, 4'd1, 4'd1, 4'd1, 4'd0};
         bus.prescale = 4'd2;
         go(4'd1, 1'b1);
         chk_all("ps.start", 4'd0, 1'b0, 1'b1, 1'b0);
         for (int i = 0; i < 12; i++) begin
            cyc(1);
            chk_all("ps.seq", ps_cnt[i], (i == 5 || i == 11), 1'b1, 1'b0);
         end
         cyc(2);
         do_stop();
         go(4'd1, 1'b1);
         cyc(2);
         chk("ps.phase0", 32'(bus.count), 32'd0);
         cyc(1);
         chk("ps.phase1", 32'(bus.count), 32'd1);
         do_stop();
      end
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
